// File: rtl/xor_event_frontend.sv
// Input event front end for an XOR gate model: per-input edge trackers with ack handshake
// and a registered gate output with a sticky protocol-error flag. Optional macro: XOR_FRONTEND_SYNC2_EN.
`timescale 1ns/1ps

module xor_event_frontend #(
  parameter bit A_INIT = 1'b0,
  parameter bit B_INIT = 1'b0,
  parameter bit E_INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic a_in,
  input  logic b_in,
  output logic a_P_,
  output logic a_M_,
  output logic b_P_,
  output logic b_M_,
  input  logic a_ack,
  input  logic b_ack,
  input  logic e_out_P,
  input  logic e_out_M,
  output logic e_out,
  output logic err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PEND_P = 2'b01,
    PEND_M = 2'b10
  } trk_state_e;

  localparam logic [1:0] LVL_INIT = {B_INIT, A_INIT};

  logic [1:0] x_in_w;
  logic [1:0] x_ack_w;
  logic [1:0] pend_p_w;
  logic [1:0] pend_m_w;
  logic [1:0] ack_idle_w;

  assign x_in_w  = {b_in, a_in};
  assign x_ack_w = {b_ack, a_ack};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_trk
      logic       sx;
      trk_state_e state_q;
      logic       lvl_q;

`ifdef XOR_FRONTEND_SYNC2_EN
      logic meta_q;
      logic sync_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          meta_q <= LVL_INIT[gi];
          sync_q <= LVL_INIT[gi];
        end else begin
          meta_q <= x_in_w[gi];
          sync_q <= meta_q;
        end
      end
`else
      logic sync_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q <= LVL_INIT[gi];
        end else begin
          sync_q <= x_in_w[gi];
        end
      end
`endif

      assign sx = sync_q;

      // Ack takes priority over a reversal; a reverted input then re-raises from IDLE.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= IDLE;
          lvl_q   <= LVL_INIT[gi];
        end else begin
          case (state_q)
            IDLE: begin
              if (sx != lvl_q) begin
                state_q <= sx ? PEND_P : PEND_M;
              end
            end
            PEND_P: begin
              if (x_ack_w[gi]) begin
                lvl_q   <= 1'b1;
                state_q <= IDLE;
              end else if (sx == lvl_q) begin
                state_q <= IDLE;
              end
            end
            PEND_M: begin
              if (x_ack_w[gi]) begin
                lvl_q   <= 1'b0;
                state_q <= IDLE;
              end else if (sx == lvl_q) begin
                state_q <= IDLE;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end

      assign pend_p_w[gi]   = (state_q == PEND_P);
      assign pend_m_w[gi]   = (state_q == PEND_M);
      assign ack_idle_w[gi] = x_ack_w[gi] && (state_q == IDLE);
    end
  endgenerate

  assign a_P_ = pend_p_w[0];
  assign a_M_ = pend_m_w[0];
  assign b_P_ = pend_p_w[1];
  assign b_M_ = pend_m_w[1];

  logic e_out_q, e_out_d;
  logic err_q, err_d;

  // Firing pulses that would not change the output level are protocol violations.
  always_comb begin
    e_out_d = e_out_q;
    err_d   = err_q | (|ack_idle_w);
    if (e_out_P && e_out_M) begin
      err_d = 1'b1;
    end else if (e_out_P) begin
      e_out_d = 1'b1;
      if (e_out_q) err_d = 1'b1;
    end else if (e_out_M) begin
      e_out_d = 1'b0;
      if (!e_out_q) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_out_q <= E_INIT;
      err_q   <= 1'b0;
    end else begin
      e_out_q <= e_out_d;
      err_q   <= err_d;
    end
  end

  assign e_out = e_out_q;
  assign err   = err_q;

endmodule

// File: tb/tb_xor_event_frontend.sv
// Self-checking bench for xor_event_frontend: vector table, directed handshake sequences
// and a randomized run against an event-level reference model.
`timescale 1ns/1ps

module tb_xor_event_frontend;

`ifdef XOR_FRONTEND_SYNC2_EN
  localparam int SYNC_N = 2;
`else
  localparam int SYNC_N = 1;
`endif
  localparam int LAT = SYNC_N + 1;
  localparam bit A_INIT = 1'b0;
  localparam bit B_INIT = 1'b0;
  localparam bit E_INIT = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_in = 1'b0, b_in = 1'b0;
  logic a_ack = 1'b0, b_ack = 1'b0;
  logic e_out_P = 1'b0, e_out_M = 1'b0;
  logic a_P_, a_M_, b_P_, b_M_, e_out, err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending event as a signed number (+1, -1, 0), input history as a delay line.
  int m_pend [2];
  bit m_lvl  [2];
  bit m_hist [2][SYNC_N];
  bit m_e;
  bit m_err;

  xor_event_frontend #(
    .A_INIT(A_INIT),
    .B_INIT(B_INIT),
    .E_INIT(E_INIT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .a_in   (a_in),
    .b_in   (b_in),
    .a_P_   (a_P_),
    .a_M_   (a_M_),
    .b_P_   (b_P_),
    .b_M_   (b_M_),
    .a_ack  (a_ack),
    .b_ack  (b_ack),
    .e_out_P(e_out_P),
    .e_out_M(e_out_M),
    .e_out  (e_out),
    .err    (err)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] dut_out();
    return {a_P_, a_M_, b_P_, b_M_, e_out, err};
  endfunction

  function automatic logic [5:0] model_out();
    return {(m_pend[0] > 0), (m_pend[0] < 0), (m_pend[1] > 0), (m_pend[1] < 0), m_e, m_err};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // Advance one clock edge and update the model with the inputs present at that edge.
  task automatic tick();
    bit r, ep, em, sx;
    bit x  [2];
    bit ak [2];
    r = reset; ep = e_out_P; em = e_out_M;
    x[0] = a_in;   x[1] = b_in;
    ak[0] = a_ack; ak[1] = b_ack;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = 0;
        m_lvl[i]  = (i == 0) ? A_INIT : B_INIT;
        for (int k = 0; k < SYNC_N; k++) m_hist[i][k] = m_lvl[i];
      end
      m_e   = E_INIT;
      m_err = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sx = m_hist[i][SYNC_N-1];
        if (m_pend[i] == 0) begin
          if (ak[i]) m_err = 1'b1;
          m_pend[i] = int'(sx) - int'(m_lvl[i]);
        end else if (ak[i]) begin
          m_lvl[i]  = (m_pend[i] > 0);
          m_pend[i] = 0;
        end else if (sx == m_lvl[i]) begin
          m_pend[i] = 0;
        end
        for (int k = SYNC_N - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = x[i];
      end
      if (ep && em) begin
        m_err = 1'b1;
      end else if (ep) begin
        if (m_e) m_err = 1'b1;
        m_e = 1'b1;
      end else if (em) begin
        if (!m_e) m_err = 1'b1;
        m_e = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_in = 1'b0; b_in = 1'b0; a_ack = 1'b0; b_ack = 1'b0; e_out_P = 1'b0; e_out_M = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    bit         ep;
    bit         em;
    bit         aack;
    bit         back;
    logic [5:0] exp;   // {a_P_, a_M_, b_P_, b_M_, e_out, err}
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 6'b000000};
    tbl[1]  = '{0, 1, 0, 0, 0, 6'b000010};
    tbl[2]  = '{0, 0, 0, 0, 0, 6'b000010};
    tbl[3]  = '{0, 1, 0, 0, 0, 6'b000011};
    tbl[4]  = '{1, 0, 0, 0, 0, 6'b000000};
    tbl[5]  = '{0, 0, 1, 0, 0, 6'b000001};
    tbl[6]  = '{1, 0, 0, 0, 0, 6'b000000};
    tbl[7]  = '{0, 1, 1, 0, 0, 6'b000001};
    tbl[8]  = '{0, 1, 0, 0, 0, 6'b000011};
    tbl[9]  = '{1, 0, 0, 0, 0, 6'b000000};
    tbl[10] = '{0, 0, 0, 0, 1, 6'b000001};
    tbl[11] = '{1, 0, 0, 0, 0, 6'b000000};
    tbl[12] = '{0, 0, 0, 1, 0, 6'b000001};
    tbl[13] = '{1, 0, 0, 0, 0, 6'b000000};

    for (int i = 0; i < 14; i++) begin
      reset = tbl[i].rst; e_out_P = tbl[i].ep; e_out_M = tbl[i].em;
      a_ack = tbl[i].aack; b_ack = tbl[i].back; a_in = 1'b0; b_in = 1'b0;
      tick();
      check($sformatf("table row %0d", i), dut_out(), tbl[i].exp);
      $display("[TB] table row %0d: outputs %b", i, dut_out());
    end
    reset = 1'b0; e_out_P = 1'b0; e_out_M = 1'b0; a_ack = 1'b0; b_ack = 1'b0;

    // a rises and is held: pending after LAT edges, cleared by ack, level then accepted.
    do_reset();
    a_in = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      check($sformatf("seqA a_P_ edge %0d", k), a_P_, (k == LAT));
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      check("seqA a_P_ held", a_P_, 1'b1);
    end
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    check("seqA after ack {a_P_,a_M_,err}", {a_P_, a_M_, err}, 3'b000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("seqA idle after ack", {a_P_, a_M_}, 2'b00);
    end
    $display("[TB] seqA: a rise, hold, ack");

    // b glitch of one synchronised cycle is absorbed.
    do_reset();
    b_in = 1'b1; tick(); b_in = 1'b0;
    check("seqB edge 1 {b_P_,b_M_,err}", {b_P_, b_M_, err}, {(LAT == 1), 2'b00});
    for (int k = 2; k <= LAT + 3; k++) begin
      tick();
      check($sformatf("seqB edge %0d {b_P_,b_M_,err}", k), {b_P_, b_M_, err}, {(k == LAT), 2'b00});
    end
    $display("[TB] seqB: b glitch absorbed");

    // Ack coincides with reversal: ack wins, opposite event follows.
    do_reset();
    a_in = 1'b1;
    repeat (LAT) tick();
    check("seqC pend_p reached", a_P_, 1'b1);
    a_in = 1'b0;
    for (int k = 0; k < SYNC_N; k++) begin
      tick();
      check("seqC still pend_p", {a_P_, a_M_}, 2'b10);
    end
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    check("seqC ack wins", {a_P_, a_M_}, 2'b00);
    tick();
    check("seqC opposite event", {a_P_, a_M_}, 2'b01);
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    check("seqC cleared, no err", {a_P_, a_M_, err}, 3'b000);
    $display("[TB] seqC: ack vs reversal");

    // Randomized run against the reference model.
    do_reset();
    check("rand reset", dut_out(), model_out());
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) a_in = ~a_in;
      if ($urandom_range(0, 7) == 0) b_in = ~b_in;
      a_ack   = ((m_pend[0] != 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 99) == 0);
      b_ack   = ((m_pend[1] != 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 99) == 0);
      e_out_P = ($urandom_range(0, 11) == 0);
      e_out_M = ($urandom_range(0, 11) == 0);
      tick();
      check($sformatf("rand cycle %0d", c), dut_out(), model_out());
    end
    $display("[TB] random run: 3000 cycles");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
